// File: rtl/i2c_master_ctrl.sv
// I2C master for single-byte memory write/read transactions.
// Write: START, dev+W, mem_addr, wdata, STOP.
// Read : START, dev+W, mem_addr, RSTART, dev+R, one byte in, master NACK, STOP.
// Each bit lasts four quarters of CLK_DIV clocks; SDA is open-drain (sda_oe=1 pulls low).
module i2c_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] mem_addr,
  input  logic [7:0] wdata,
  input  logic       sda_in,
  output logic       scl,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_START  = 4'd1;
  localparam logic [3:0] S_ADDR   = 4'd2;
  localparam logic [3:0] S_ACK1   = 4'd3;
  localparam logic [3:0] S_MADDR  = 4'd4;
  localparam logic [3:0] S_ACK2   = 4'd5;
  localparam logic [3:0] S_WDATA  = 4'd6;
  localparam logic [3:0] S_ACK3   = 4'd7;
  localparam logic [3:0] S_RSTART = 4'd8;
  localparam logic [3:0] S_RADDR  = 4'd9;
  localparam logic [3:0] S_ACK4   = 4'd10;
  localparam logic [3:0] S_RDATA  = 4'd11;
  localparam logic [3:0] S_MNACK  = 4'd12;
  localparam logic [3:0] S_STOP   = 4'd13;

  logic [3:0]    state;
  logic [DW-1:0] div_cnt;
  logic [1:0]    q;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          rw_r;
  logic [6:0]    dev_r;
  logic [7:0]    mem_r;
  logic [7:0]    wdata_r;
  logic          sda_smp;
  logic          err;
  logic          tick;
  logic          sample;
  logic          bit_end;

  assign tick    = (div_cnt == DIV_LAST);
  assign sample  = tick && (q == 2'd2);
  assign bit_end = tick && (q == 2'd3);

  // Quarter-period timebase; held at zero while idle so every bit starts aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      q       <= '0;
    end else if (state == S_IDLE) begin
      div_cnt <= '0;
      q       <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      q       <= q + 2'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Transaction sequencer: request latch, byte shifting, ACK evaluation, completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rdata   <= '0;
      rw_r    <= 1'b0;
      dev_r   <= '0;
      mem_r   <= '0;
      wdata_r <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      sda_smp <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        // A request coinciding with the done pulse waits one more cycle.
        if (start && !done) begin
          rw_r    <= rw;
          dev_r   <= dev_addr;
          mem_r   <= mem_addr;
          wdata_r <= wdata;
          ack_err <= 1'b0;
          err     <= 1'b0;
          busy    <= 1'b1;
          bit_cnt <= '0;
          state   <= S_START;
        end
      end else begin
        if (sample) begin
          sda_smp <= sda_in;
          if (state == S_RDATA) shreg <= {shreg[6:0], sda_in};
        end
        if (bit_end) begin
          case (state)
            S_START: begin
              shreg <= {dev_r, 1'b0};
              state <= S_ADDR;
            end
            S_ADDR, S_MADDR, S_WDATA, S_RADDR: begin
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                case (state)
                  S_ADDR:  state <= S_ACK1;
                  S_MADDR: state <= S_ACK2;
                  S_WDATA: state <= S_ACK3;
                  default: state <= S_ACK4;
                endcase
              end
            end
            S_ACK1: begin
              if (sda_smp) begin
                err   <= 1'b1;
                state <= S_STOP;
              end else begin
                shreg <= mem_r;
                state <= S_MADDR;
              end
            end
            S_ACK2: begin
              if (sda_smp) begin
                err   <= 1'b1;
                state <= S_STOP;
              end else if (rw_r) begin
                state <= S_RSTART;
              end else begin
                shreg <= wdata_r;
                state <= S_WDATA;
              end
            end
            S_ACK3: begin
              if (sda_smp) err <= 1'b1;
              state <= S_STOP;
            end
            S_RSTART: begin
              shreg <= {dev_r, 1'b1};
              state <= S_RADDR;
            end
            S_ACK4: begin
              if (sda_smp) begin
                err   <= 1'b1;
                state <= S_STOP;
              end else begin
                state <= S_RDATA;
              end
            end
            S_RDATA: begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= S_MNACK;
            end
            S_MNACK: state <= S_STOP;
            S_STOP: begin
              state   <= S_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              ack_err <= err;
              if (rw_r && !err) rdata <= shreg;
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

  // Line drive decoded from state and quarter; idle/reset leaves SCL high and SDA released.
  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    case (state)
      S_IDLE: begin
        scl    = 1'b1;
        sda_oe = 1'b0;
      end
      S_START, S_RSTART: begin
        scl    = (q == 2'd1) || (q == 2'd2);
        sda_oe = q[1];
      end
      S_STOP: begin
        scl    = (q != 2'd0);
        sda_oe = ~q[1];
      end
      S_ADDR, S_MADDR, S_WDATA, S_RADDR: begin
        scl    = q[1];
        sda_oe = ~shreg[7];
      end
      default: begin
        scl    = q[1];
        sda_oe = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with CLK_DIV=2 (8 clocks per bit).
// A cycle-indexed slave schedule drives SDA; a line monitor logs one SDA bit per SCL rise
// and counts SDA edges while SCL is high (START = falling, STOP = rising).
module tb_i2c_master_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] mem_addr = '0;
  logic [7:0] wdata = '0;
  logic       slave_sda = 1'b1;
  logic       sda_line;
  logic       scl;
  logic       sda_oe;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [7:0] rdata;

  assign sda_line = sda_oe ? 1'b0 : slave_sda;

  i2c_master_ctrl #(.CLK_DIV(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rw       (rw),
    .dev_addr (dev_addr),
    .mem_addr (mem_addr),
    .wdata    (wdata),
    .sda_in   (sda_line),
    .scl      (scl),
    .sda_oe   (sda_oe),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err),
    .rdata    (rdata)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_bad = 0;
  logic bitlog [0:1023];
  int   nbits = 0;
  int   nstart = 0;
  int   nstop = 0;
  logic prev_scl = 1'b1;
  logic prev_sda = 1'b1;
  logic sched [0:63];
  int   bit_base = 0;
  int   st_base = 0;
  int   sp_base = 0;
  int   lat;

  // Line monitor, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (prev_scl && scl && (sda_line != prev_sda)) begin
      if (!sda_line) nstart++;
      else           nstop++;
    end
    if (!prev_scl && scl) begin
      if (nbits < 1024) bitlog[nbits] = sda_line;
      nbits++;
    end
    prev_scl = scl;
    prev_sda = sda_line;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_at(input int idx);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) b = {b[6:0], bitlog[(bit_base + idx + i) & 1023]};
    return b;
  endfunction

  task automatic sched_clear;
    for (int i = 0; i < 64; i++) sched[i] = 1'b1;
  endtask

  task automatic mark;
    bit_base = nbits;
    st_base  = nstart;
    sp_base  = nstop;
  endtask

  task automatic set_req(input logic r, input logic [6:0] d, input logic [7:0] m, input logic [7:0] w);
    rw       = r;
    dev_addr = d;
    mem_addr = m;
    wdata    = w;
  endtask

  task automatic launch(input string tag, input logic r, input logic [6:0] d,
                        input logic [7:0] m, input logic [7:0] w);
    set_req(r, d, m, w);
    mark;
    start = 1'b1;
    step;
    start = 1'b0;
    check({tag, "_accept_busy"}, busy, 1);
    check({tag, "_accept_err_clr"}, ack_err, 0);
  endtask

  // Steps from busy-rise-relative cycle n0 until done, abort_at, or the cycle bound.
  task automatic run(input int n0, input int abort_at, output int n_out);
    int n;
    n = n0;
    while (!done && n < 1000 && n != abort_at) begin
      slave_sda = sched[(n >> 3) & 63];
      step;
      n++;
    end
    n_out = n;
  endtask

  task automatic write_acks;
    sched_clear;
    sched[9]  = 1'b0;
    sched[18] = 1'b0;
    sched[27] = 1'b0;
  endtask

  task automatic check_write(input string tag, input logic [7:0] m, input logic [7:0] w);
    check({tag, "_lat"}, lat, 232);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_ack_err"}, ack_err, 0);
    check({tag, "_byte_addr"}, byte_at(1), 8'hA0);
    check({tag, "_byte_mem"}, byte_at(10), m);
    check({tag, "_byte_data"}, byte_at(19), w);
    check({tag, "_nbits"}, nbits - bit_base, 29);
    check({tag, "_starts"}, nstart - st_base, 1);
    check({tag, "_stops"}, nstop - sp_base, 1);
  endtask

  initial begin
    logic [7:0] rb;
    sched_clear;

    // Reset
    #1 rst = 1'b0;
    #2;
    check("rst_scl", scl, 1);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_rdata", rdata, 8'h00);
    step;
    rst = 1'b1;
    step;
    step;

    // 1: write with ACKs
    write_acks;
    launch("t1", 1'b0, 7'h50, 8'h05, 8'hAB);
    run(0, -1, lat);
    check_write("t1", 8'h05, 8'hAB);
    check("t1_ack1_bit", bitlog[(bit_base + 9) & 1023], 0);
    slave_sda = 1'b1;
    step;
    check("t1_done_one_cycle", done, 0);

    // 2: read returning 0x3C
    sched_clear;
    sched[9]  = 1'b0;
    sched[18] = 1'b0;
    sched[28] = 1'b0;
    rb = 8'h3C;
    for (int i = 0; i < 8; i++) sched[29 + i] = rb[7 - i];
    launch("t2", 1'b1, 7'h50, 8'h05, 8'h00);
    run(0, -1, lat);
    check("t2_lat", lat, 312);
    check("t2_done", done, 1);
    check("t2_busy_low", busy, 0);
    check("t2_ack_err", ack_err, 0);
    check("t2_rdata", rdata, 8'h3C);
    check("t2_byte_addr_w", byte_at(1), 8'hA0);
    check("t2_byte_mem", byte_at(10), 8'h05);
    check("t2_byte_addr_r", byte_at(20), 8'hA1);
    check("t2_byte_line", byte_at(29), 8'h3C);
    check("t2_mnack", bitlog[(bit_base + 37) & 1023], 1);
    check("t2_nbits", nbits - bit_base, 39);
    check("t2_starts", nstart - st_base, 2);
    check("t2_stops", nstop - sp_base, 1);
    slave_sda = 1'b1;
    step;

    // 3: write, no slave present
    sched_clear;
    launch("t3", 1'b0, 7'h50, 8'h05, 8'hAB);
    run(0, -1, lat);
    check("t3_lat", lat, 88);
    check("t3_ack_err", ack_err, 1);
    check("t3_busy_low", busy, 0);
    check("t3_nbits", nbits - bit_base, 11);
    check("t3_stops", nstop - sp_base, 1);
    check("t3_rdata_hold", rdata, 8'h3C);
    step;
    step;
    check("t3_ack_err_held", ack_err, 1);

    // 4: read, NACK on memory address byte
    sched_clear;
    sched[9] = 1'b0;
    launch("t4", 1'b1, 7'h50, 8'h05, 8'h00);
    run(0, -1, lat);
    check("t4_lat", lat, 160);
    check("t4_ack_err", ack_err, 1);
    check("t4_rdata_hold", rdata, 8'h3C);
    check("t4_nbits", nbits - bit_base, 20);
    check("t4_starts", nstart - st_base, 1);
    check("t4_stops", nstop - sp_base, 1);
    slave_sda = 1'b1;
    step;

    // 5: start ignored mid-transaction and in the done cycle
    write_acks;
    launch("t5", 1'b0, 7'h50, 8'h12, 8'h5A);
    run(0, 48, lat);
    set_req(1'b1, 7'h11, 8'hFF, 8'h00);
    start = 1'b1;
    slave_sda = sched[6];
    step;
    start = 1'b0;
    check("t5_mid_busy", busy, 1);
    run(49, -1, lat);
    check_write("t5", 8'h12, 8'h5A);
    slave_sda = 1'b1;
    set_req(1'b0, 7'h50, 8'h06, 8'hC3);
    start = 1'b1;
    step;
    check("t5_done_cycle_ignored", busy, 0);
    mark;
    step;
    start = 1'b0;
    check("t5_accept_next", busy, 1);
    write_acks;
    run(0, -1, lat);
    check_write("t5b", 8'h06, 8'hC3);
    slave_sda = 1'b1;
    step;

    // 6: reset during data byte, then a clean write
    write_acks;
    launch("t6", 1'b0, 7'h50, 8'h07, 8'h99);
    run(0, 160, lat);
    check("t6_in_flight", busy, 1);
    rst = 1'b0;
    #1;
    check("t6_rst_scl", scl, 1);
    check("t6_rst_sda_oe", sda_oe, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_rdata", rdata, 8'h00);
    slave_sda = 1'b1;
    step;
    rst = 1'b1;
    step;
    check("t6_idle_busy", busy, 0);
    write_acks;
    launch("t6b", 1'b0, 7'h50, 8'h08, 8'h7E);
    run(0, -1, lat);
    check_write("t6b", 8'h08, 8'h7E);
    slave_sda = 1'b1;
    step;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
